// File: rtl/dcache_resp_pkg.sv
// rtl/dcache_resp_pkg.sv - shared state encoding and geometry helpers for dcache_resp
package dcache_resp_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_LINES  = 16;
    localparam int DEF_WORDS  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_WRITE  = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    function automatic int calc_off_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int calc_idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int calc_tag_w(input int addr_w, input int lines, input int words);
        return addr_w - 2 - $clog2(words) - $clog2(lines);
    endfunction

endpackage

// File: rtl/dcache_tagarray.sv
// rtl/dcache_tagarray.sv - per-line valid bit and tag store with synchronous clear-all
module dcache_tagarray #(
    parameter int LINES = 16,
    parameter int TAG_W = 24
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [$clog2(LINES)-1:0] rd_idx,
    output logic                     rd_valid,
    output logic [TAG_W-1:0]         rd_tag,
    input  logic                     wr_en,
    input  logic [$clog2(LINES)-1:0] wr_idx,
    input  logic                     wr_valid,
    input  logic [TAG_W-1:0]         wr_tag
);

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags [LINES];

    always_ff @(posedge clk) begin
        if (clr) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= wr_valid;
        end
    end

    // Tags need no reset: a tag is only trusted when its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx] <= wr_tag;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];

endmodule

// File: rtl/dcache_resp.sv
// rtl/dcache_resp.sv - direct-mapped write-through no-write-allocate data cache responder
module dcache_resp
    import dcache_resp_pkg::*;
#(
    parameter int ADDR_MEM_WIDTH = DEF_ADDR_W,
    parameter int LINES          = DEF_LINES,
    parameter int WORDS          = DEF_WORDS
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [ADDR_MEM_WIDTH-1:0] i_addr,
    input  logic [31:0]               i_data,
    input  logic                      i_we,
    input  logic                      i_re,
    output logic [31:0]               o_data,
    output logic                      o_valid,
    output logic                      o_busy,
    output logic [ADDR_MEM_WIDTH-1:0] o_mem_addr,
    output logic                      o_mem_req,
    output logic                      o_mem_we,
    output logic [31:0]               o_mem_wdata,
    input  logic [31:0]               i_mem_rdata,
    input  logic                      i_mem_ack
);

    localparam int OFF_W = calc_off_w(WORDS);
    localparam int IDX_W = calc_idx_w(LINES);
    localparam int TAG_W = calc_tag_w(ADDR_MEM_WIDTH, LINES, WORDS);

    state_t             state, state_nx;
    logic [OFF_W-1:0]   beat, off_q;
    logic [IDX_W-1:0]   idx_q;
    logic [TAG_W-1:0]   tag_q;
    logic [31:0]        wdata_q, data_q;
    logic               valid_q;
    logic [31:0]        data_mem [LINES][WORDS];

    logic [OFF_W-1:0]   in_off;
    logic [IDX_W-1:0]   in_idx;
    logic [TAG_W-1:0]   in_tag;
    logic               line_valid, hit, accept, ack_beat, last_beat;
    logic [TAG_W-1:0]   line_tag;
    logic               tag_wr_en, tag_wr_valid;
    logic [IDX_W-1:0]   tag_wr_idx;
    logic               unused_addr_lsb;

    assign in_off          = i_addr[2 +: OFF_W];
    assign in_idx          = i_addr[2 + OFF_W +: IDX_W];
    assign in_tag          = i_addr[ADDR_MEM_WIDTH-1 -: TAG_W];
    assign unused_addr_lsb = ^i_addr[1:0];

    dcache_tagarray #(
        .LINES (LINES),
        .TAG_W (TAG_W)
    ) u_tagarray (
        .clk      (i_clk),
        .clr      (~i_rst_n),
        .rd_idx   (in_idx),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .wr_en    (tag_wr_en),
        .wr_idx   (tag_wr_idx),
        .wr_valid (tag_wr_valid),
        .wr_tag   (tag_q)
    );

    assign hit       = line_valid && (line_tag == in_tag);
    assign o_busy    = (state == ST_REFILL) || (state == ST_WRITE);
    assign accept    = (i_re || i_we) && !o_busy;
    assign ack_beat  = (state == ST_REFILL) && i_mem_ack;
    assign last_beat = (beat == OFF_W'(WORDS - 1));
    assign o_valid   = valid_q;
    assign o_data    = data_q;

    // The line is invalidated as the refill starts, so a half-filled line never hits.
    always_comb begin
        tag_wr_en    = 1'b0;
        tag_wr_idx   = idx_q;
        tag_wr_valid = 1'b0;
        if (accept && !i_we && !hit) begin
            tag_wr_en  = 1'b1;
            tag_wr_idx = in_idx;
        end else if (ack_beat && last_beat) begin
            tag_wr_en    = 1'b1;
            tag_wr_valid = 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_RESP: begin
                state_nx = ST_IDLE;
                if (accept) begin
                    if (i_we) begin
                        state_nx = ST_WRITE;
                    end else if (!hit) begin
                        state_nx = ST_REFILL;
                    end
                end
            end
            ST_REFILL: if (i_mem_ack && last_beat) state_nx = ST_RESP;
            ST_WRITE:  if (i_mem_ack) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (state == ST_REFILL) begin
            o_mem_req  = 1'b1;
            o_mem_addr = {tag_q, idx_q, beat, 2'b00};
        end else if (state == ST_WRITE) begin
            o_mem_req   = 1'b1;
            o_mem_we    = 1'b1;
            o_mem_addr  = {tag_q, idx_q, off_q, 2'b00};
            o_mem_wdata = wdata_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            beat    <= '0;
            off_q   <= '0;
            idx_q   <= '0;
            tag_q   <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nx;
            valid_q <= 1'b0;
            if (accept) begin
                off_q   <= in_off;
                idx_q   <= in_idx;
                tag_q   <= in_tag;
                wdata_q <= i_data;
                beat    <= '0;
                if (!i_we && hit) begin
                    valid_q <= 1'b1;
                    data_q  <= data_mem[in_idx][in_off];
                end
            end
            if (ack_beat) begin
                beat <= beat + 1'b1;
                if (beat == off_q) data_q <= i_mem_rdata;
                if (last_beat) valid_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept && i_we && hit) begin
            data_mem[in_idx][in_off] <= i_data;
        end else if (ack_beat) begin
            data_mem[idx_q][beat] <= i_mem_rdata;
        end
    end

endmodule

// File: tb/tb_dcache_resp.sv
// tb/tb_dcache_resp.sv - directed vector bench for dcache_resp
module tb_dcache_resp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_data = '0;
    logic        i_we = 1'b0;
    logic        i_re = 1'b0;
    logic [31:0] o_data;
    logic        o_valid;
    logic        o_busy;
    logic [31:0] o_mem_addr;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata = '0;
    logic        i_mem_ack = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    int ack_wait = 2;

    typedef struct {
        bit          we;
        logic [31:0] addr;
    } txn_t;
    txn_t txq[$];

    logic [31:0] mem [logic [31:0]];

    typedef struct {
        bit          re;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          aw;
        int          exp_valid;
        logic [31:0] exp_data;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] exp_first;
        int          exp_lat;
    } vec_t;

    dcache_resp dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_addr      (i_addr),
        .i_data      (i_data),
        .i_we        (i_we),
        .i_re        (i_re),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_busy      (o_busy),
        .o_mem_addr  (o_mem_addr),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_ack   (i_mem_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'hBAD0_0000 | {16'h0, a[15:0]};
    endfunction

    // Backing memory: acks each beat after ack_wait idle negedges.
    initial begin
        int cnt = 0;
        forever begin
            @(negedge clk);
            i_mem_ack = 1'b0;
            if (rst_n && o_mem_req) begin
                if (cnt >= ack_wait) begin
                    i_mem_ack = 1'b1;
                    if (o_mem_we) mem[o_mem_addr] = o_mem_wdata;
                    i_mem_rdata = o_mem_we ? 32'h0 : mem_rd(o_mem_addr);
                    txq.push_back('{we: o_mem_we, addr: o_mem_addr});
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(bit re, bit we, logic [31:0] addr, logic [31:0] wdata, int aw,
                                int ev, logic [31:0] ed, int rd, int wr, logic [31:0] fa, int lat);
        vec_t v;
        v.re = re; v.we = we; v.addr = addr; v.wdata = wdata; v.aw = aw;
        v.exp_valid = ev; v.exp_data = ed; v.exp_rd = rd; v.exp_wr = wr;
        v.exp_first = fa; v.exp_lat = lat;
        return v;
    endfunction

    task automatic run_op(input vec_t v, input string name);
        int lat = 1;
        int vcount = 0;
        int rd = 0;
        int wr = 0;
        bit done = 0;
        logic [31:0] got_d = '0;
        ack_wait = v.aw;
        txq.delete();
        i_re = v.re; i_we = v.we; i_addr = v.addr; i_data = v.wdata;
        @(negedge clk);
        i_re = 1'b0; i_we = 1'b0;
        while (!done && lat <= 100) begin
            if (o_valid) begin
                vcount++;
                got_d = o_data;
            end
            if (!o_busy) done = 1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        chk({name, "_timeout"}, 32'(done), 32'd1);
        @(negedge clk);
        if (o_valid) vcount++;
        foreach (txq[k]) begin
            if (txq[k].we) wr++;
            else rd++;
        end
        chk({name, "_valid_pulses"}, 32'(vcount), 32'(v.exp_valid));
        if (v.exp_valid != 0) chk({name, "_data"}, got_d, v.exp_data);
        chk({name, "_rd_beats"}, 32'(rd), 32'(v.exp_rd));
        chk({name, "_wr_beats"}, 32'(wr), 32'(v.exp_wr));
        if (txq.size() > 0) chk({name, "_first_addr"}, txq[0].addr, v.exp_first);
        chk({name, "_latency"}, 32'(lat), 32'(v.exp_lat));
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_valid"},  32'(o_valid),   32'd0);
        chk({name, "_busy"},   32'(o_busy),    32'd0);
        chk({name, "_req"},    32'(o_mem_req), 32'd0);
        chk({name, "_mem_we"}, 32'(o_mem_we),  32'd0);
        chk({name, "_addr"},   o_mem_addr,     32'd0);
        chk({name, "_wdata"},  o_mem_wdata,    32'd0);
        chk({name, "_data"},   o_data,         32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[15];
        int   n;

        mem[32'h100] = 32'hA0; mem[32'h104] = 32'hA1;
        mem[32'h108] = 32'hA2; mem[32'h10C] = 32'hA3;
        mem[32'h200] = 32'hB0; mem[32'h204] = 32'hB1;
        mem[32'h208] = 32'hB2; mem[32'h20C] = 32'hB3;

        // re, we, addr, wdata, ack_wait, valid pulses, data, rd beats, wr beats, first addr, latency
        vecs[0]  = mk(1, 0, 32'h100, 0,             2, 1, 32'hA0,        4, 0, 32'h100, 13);
        vecs[1]  = mk(1, 0, 32'h108, 0,             2, 1, 32'hA2,        0, 0, 32'h0,    1);
        vecs[2]  = mk(0, 1, 32'h104, 32'hDEADBEEF,  2, 0, 32'h0,         0, 1, 32'h104,  4);
        vecs[3]  = mk(1, 0, 32'h104, 0,             2, 1, 32'hDEADBEEF,  0, 0, 32'h0,    1);
        vecs[4]  = mk(0, 1, 32'h200, 32'h12345678,  2, 0, 32'h0,         0, 1, 32'h200,  4);
        vecs[5]  = mk(1, 0, 32'h200, 0,             2, 1, 32'h12345678,  4, 0, 32'h200, 13);
        vecs[6]  = mk(1, 0, 32'h100, 0,             2, 1, 32'hA0,        4, 0, 32'h100, 13);
        vecs[7]  = mk(1, 0, 32'h10C, 0,             2, 1, 32'hA3,        0, 0, 32'h0,    1);
        vecs[8]  = mk(1, 0, 32'h104, 0,             2, 1, 32'hDEADBEEF,  0, 0, 32'h0,    1);
        vecs[9]  = mk(1, 1, 32'h108, 32'h55,        2, 0, 32'h0,         0, 1, 32'h108,  4);
        vecs[10] = mk(1, 0, 32'h108, 0,             2, 1, 32'h55,        0, 0, 32'h0,    1);
        vecs[11] = mk(1, 0, 32'h20C, 0,             2, 1, 32'hB3,        4, 0, 32'h200, 13);
        vecs[12] = mk(1, 0, 32'h1F4, 0,             0, 1, 32'hBAD001F4,  4, 0, 32'h1F0,  5);
        vecs[13] = mk(0, 1, 32'h1F4, 32'h0F0F0F0F,  0, 0, 32'h0,         0, 1, 32'h1F4,  2);
        vecs[14] = mk(1, 0, 32'h1F4, 0,             0, 1, 32'h0F0F0F0F,  0, 0, 32'h0,    1);

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i], $sformatf("v%0d", i));
        end

        // A request issued in the RESP cycle is accepted immediately.
        ack_wait = 2;
        txq.delete();
        i_re = 1'b1; i_addr = 32'h300;
        @(negedge clk);
        i_re = 1'b0;
        n = 0;
        while (!o_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("resp_seen", 32'(o_valid), 32'd1);
        chk("resp_data", o_data, 32'hBAD00300);
        chk("resp_busy", 32'(o_busy), 32'd0);
        i_re = 1'b1; i_addr = 32'h1F4;
        @(negedge clk);
        i_re = 1'b0;
        chk("b2b_valid", 32'(o_valid), 32'd1);
        chk("b2b_data", o_data, 32'h0F0F0F0F);
        chk("b2b_rd_beats", 32'(txq.size()), 32'd4);
        @(negedge clk);

        // Reset in the middle of a refill abandons it and invalidates every line.
        txq.delete();
        i_re = 1'b1; i_addr = 32'h400;
        @(negedge clk);
        i_re = 1'b0;
        n = 0;
        while (txq.size() < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("midreset_beats_before", 32'(txq.size()), 32'd2);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midreset");
        rst_n = 1'b1;
        @(negedge clk);
        run_op(mk(1, 0, 32'h400, 0, 2, 1, 32'hBAD00400, 4, 0, 32'h400, 13), "after_reset_400");
        run_op(mk(1, 0, 32'h1F4, 0, 2, 1, 32'h0F0F0F0F, 4, 0, 32'h1F0, 13), "after_reset_1f4");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_resp.md
Name: dcache_resp

Overview:
- Data-cache responder on the far side of the core's Dcache port: serves loads/stores the core issues on address/data/we.
- Direct-mapped, write-through, no-write-allocate, multi-word lines.
- Misses are refilled from a simple req/ack backing-memory port, one word per beat.
- Sits between the core's MEM execute path and the external memory/bus.

Parameters:
- ADDR_MEM_WIDTH, 32, byte-address width (matches core port).
- LINES, 16, number of cache lines (power of 2).
- WORDS, 4, 32-bit words per line (power of 2, >=2).

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  synchronous active-low reset
- i_addr  input  ADDR_MEM_WIDTH  core byte address; bits [1:0] ignored
- i_data  input  32  core store data
- i_we  input  1  store request
- i_re  input  1  load request
- o_data  output  32  load result
- o_valid  output  1  o_data valid (one-cycle pulse per load)
- o_busy  output  1  requests not accepted this cycle
- o_mem_addr  output  ADDR_MEM_WIDTH  backing-memory word address (byte address, [1:0]=0)
- o_mem_req  output  1  backing-memory request
- o_mem_we  output  1  backing-memory write
- o_mem_wdata  output  32  backing-memory write data
- i_mem_rdata  input  32  backing-memory read data
- i_mem_ack  input  1  beat complete; i_mem_rdata valid this cycle for reads

Behaviour:
- Address split: off = log2(WORDS) bits above [1:0]; idx = log2(LINES) bits; tag = remaining upper bits.
- Storage per line: valid bit, tag, WORDS x 32 data.
- Request accepted when (i_re|i_we) & ~o_busy.
- If i_re and i_we are both high, the request is a store; no o_valid is produced.
- States: IDLE, REFILL, WRITE, RESP.
- IDLE, load hit: next cycle o_valid=1, o_data = cached word; stay IDLE.
- IDLE, load miss: next cycle enter REFILL, beat counter = 0. Latch requested word offset.
- IDLE, store: if hit, the cached word is updated at the clock edge. Always enter WRITE with latched addr/data. A store miss does not allocate.
- REFILL:
  - o_mem_req=1, o_mem_we=0, o_mem_addr = {tag, idx, beat, 2'b00}.
  - On i_mem_ack: write i_mem_rdata into data[idx][beat]; beat+1.
  - If the acked word is the requested offset, capture it to the response register.
  - Ack on the last beat (beat=WORDS-1): set valid and tag for idx, go to RESP.
  - Line valid is cleared on entry to REFILL, so a partial line is never a hit.
- RESP: o_valid=1 for exactly one cycle with the captured word; o_busy=0, so a new request can be accepted in the same cycle. Next state IDLE, or per accept rules.
- WRITE: o_mem_req=1, o_mem_we=1, latched addr/data. On i_mem_ack, go to IDLE. No o_valid for stores.
- o_busy=1 in REFILL and WRITE; 0 in IDLE and RESP.
- o_mem_req/addr/we/wdata stay stable until ack. The memory may ack in the same cycle req rises (minimum 1 cycle per beat).
- Latency:
  - Load hit: 1 cycle.
  - Load miss: 1 + sum(ack waits) + 1.
  - Store: 1 + ack wait.
- Conflict: a miss on a valid line with a different tag overwrites it (no writeback; write-through keeps memory coherent).
- Reset values (reset is synchronous; applies mid-operation too):
  - state=IDLE, all valid bits=0, beat=0.
  - o_valid=0, o_busy=0, o_mem_req=0, o_mem_we=0, o_data=0, o_mem_addr=0, o_mem_wdata=0.
  - An in-flight memory request is abandoned; a late i_mem_ack in IDLE is ignored.
- i_mem_ack outside REFILL/WRITE is ignored.
- Data array contents are not reset.

Decomposition:
- Shared package:
  - State encoding localparams (IDLE, REFILL, WRITE, RESP).
  - Derived width constants: OFF_W=$clog2(WORDS), IDX_W=$clog2(LINES), TAG_W=ADDR_MEM_WIDTH-2-OFF_W-IDX_W.
- One sub-module, dcache_tagarray: valid+tag store with read port, write port and synchronous clear-all. The data array stays inline.

Test Plan:
- Cold load 0x100, memory acks each beat after 2 cycles returning 0xA0,0xA1,0xA2,0xA3 -> 4 reads at 0x100,0x104,0x108,0x10C; o_valid=1, o_data=0xA0 in the cycle after the 4th ack; o_busy high throughout the refill.
- Load 0x108 right after that refill -> o_valid next cycle, o_data=0xA2, o_mem_req stays 0.
- Store 0xDEADBEEF to 0x104 (hit) -> one write beat at 0x104; subsequent load 0x104 hits, returning 0xDEADBEEF.
- Store to 0x200 (miss), then load 0x200 -> store does not allocate; the load triggers a full refill at 0x200.
- Load 0x100, then load 0x200 (same idx, LINES=16, WORDS=4) -> each misses; line 0x100 is evicted, and reloading 0x100 refills again.
- Assert i_rst_n=0 during beat 2 of a refill, then load the same address -> outputs at reset values, o_mem_req=0; the load misses and restarts at beat 0.
